// File: rtl/idli_fetch_m.sv
// Instruction fetch: reads 16-bit words from memory and streams them to execute one nibble per cycle.
// Optional macro IDLI_FETCH_PREFETCH_EN adds a second word buffer for back-to-back streaming.
module idli_fetch_m (
    input  logic        i_fe_gck,
    input  logic        i_fe_rst,
    input  logic        i_fe_mem_ack,
    input  logic [15:0] i_fe_mem_data,
    output logic        o_fe_mem_req,
    output logic [15:0] o_fe_mem_addr,
    input  logic        i_fe_redir,
    input  logic [15:0] i_fe_redir_pc,
    output logic [1:0]  o_fe_ctr,
    output logic [3:0]  o_fe_enc,
    output logic        o_fe_enc_vld
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [1:0]  state_r, state_nxt_s;
    logic [1:0]  ctr_r, ctr_nxt_s;
    logic [15:0] pc_r, pc_nxt_s;
    logic [15:0] buf0_r, buf0_nxt_s;
    logic        req_r, req_nxt_s;
    logic [15:0] addr_r, addr_nxt_s;
    logic        discard_r, discard_nxt_s;
    logic [3:0]  enc_r, enc_nxt_s;
    logic        enc_vld_r, enc_vld_nxt_s;
    logic        ack_s, take_s;
`ifdef IDLI_FETCH_PREFETCH_EN
    logic [15:0] buf1_r, buf1_nxt_s;
    logic        buf1_vld_r, buf1_vld_nxt_s;
`endif

    function automatic logic [3:0] nibble_sel(input logic [15:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    nibble_sel = word[3:0];
            2'd1:    nibble_sel = word[7:4];
            2'd2:    nibble_sel = word[11:8];
            default: nibble_sel = word[15:12];
        endcase
    endfunction

    // Next-state, buffer, request and encoding computation
    always_comb begin
        ack_s         = i_fe_mem_ack & req_r;
        take_s        = ack_s & ~discard_r & ~i_fe_redir;
        ctr_nxt_s     = ctr_r + 2'd1;
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        buf0_nxt_s    = buf0_r;
        discard_nxt_s = ack_s ? 1'b0 : discard_r;
`ifdef IDLI_FETCH_PREFETCH_EN
        buf1_nxt_s     = buf1_r;
        buf1_vld_nxt_s = buf1_vld_r;
`endif
        if (i_fe_redir) begin
            // A request still in flight must complete, but its data is stale
            state_nxt_s   = ST_FETCH;
            pc_nxt_s      = i_fe_redir_pc;
            discard_nxt_s = req_r & ~ack_s;
`ifdef IDLI_FETCH_PREFETCH_EN
            buf1_vld_nxt_s = 1'b0;
`endif
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (take_s) begin
                        buf0_nxt_s  = i_fe_mem_data;
                        pc_nxt_s    = pc_r + 16'd1;
                        state_nxt_s = (ctr_r == 2'd3) ? ST_STREAM : ST_WAIT;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    state_nxt_s = (ctr_r == 2'd3) ? ST_STREAM : ST_WAIT;
                end
                ST_STREAM: begin
`ifdef IDLI_FETCH_PREFETCH_EN
                    if (take_s) begin
                        pc_nxt_s = pc_r + 16'd1;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                    if (ctr_r == 2'd3) begin
                        // Word boundary: continue from the spare buffer or straight from memory
                        if (buf1_vld_r) begin
                            buf0_nxt_s     = buf1_r;
                            buf1_vld_nxt_s = 1'b0;
                            state_nxt_s    = ST_STREAM;
                        end else if (take_s) begin
                            buf0_nxt_s  = i_fe_mem_data;
                            state_nxt_s = ST_STREAM;
                        end else begin
                            state_nxt_s = ST_FETCH;
                        end
                    end else begin
                        if (take_s) begin
                            buf1_nxt_s     = i_fe_mem_data;
                            buf1_vld_nxt_s = 1'b1;
                        end else begin
                            buf1_vld_nxt_s = buf1_vld_r;
                        end
                        state_nxt_s = ST_STREAM;
                    end
`else
                    state_nxt_s = (ctr_r == 2'd3) ? ST_FETCH : ST_STREAM;
`endif
                end
                default: begin
                    state_nxt_s = ST_FETCH;
                end
            endcase
        end

        if (req_r & ~ack_s) begin
            req_nxt_s  = 1'b1;
            addr_nxt_s = addr_r;
        end else begin
`ifdef IDLI_FETCH_PREFETCH_EN
            req_nxt_s = (state_nxt_s == ST_FETCH) |
                        ((state_nxt_s == ST_STREAM) & ~buf1_vld_nxt_s);
`else
            req_nxt_s = (state_nxt_s == ST_FETCH);
`endif
            addr_nxt_s = pc_nxt_s;
        end

        enc_vld_nxt_s = (state_nxt_s == ST_STREAM);
        if (enc_vld_nxt_s) begin
            enc_nxt_s = nibble_sel(buf0_nxt_s, ctr_nxt_s);
        end else begin
            enc_nxt_s = 4'd0;
        end
    end

    // State and output registers
    always_ff @(posedge i_fe_gck) begin
        if (i_fe_rst) begin
            state_r   <= ST_FETCH;
            ctr_r     <= 2'd0;
            pc_r      <= 16'd0;
            buf0_r    <= 16'd0;
            req_r     <= 1'b0;
            addr_r    <= 16'd0;
            discard_r <= 1'b0;
            enc_r     <= 4'd0;
            enc_vld_r <= 1'b0;
`ifdef IDLI_FETCH_PREFETCH_EN
            buf1_r     <= 16'd0;
            buf1_vld_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            ctr_r     <= ctr_nxt_s;
            pc_r      <= pc_nxt_s;
            buf0_r    <= buf0_nxt_s;
            req_r     <= req_nxt_s;
            addr_r    <= addr_nxt_s;
            discard_r <= discard_nxt_s;
            enc_r     <= enc_nxt_s;
            enc_vld_r <= enc_vld_nxt_s;
`ifdef IDLI_FETCH_PREFETCH_EN
            buf1_r     <= buf1_nxt_s;
            buf1_vld_r <= buf1_vld_nxt_s;
`endif
        end
    end

    assign o_fe_mem_req  = req_r;
    assign o_fe_mem_addr = addr_r;
    assign o_fe_ctr      = ctr_r;
    assign o_fe_enc      = enc_r;
    assign o_fe_enc_vld  = enc_vld_r;

endmodule
